// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked 16-opcode ALU with single-cycle ops and iterative restoring divide/modulo.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reg0,
    input  logic [WIDTH-1:0] reg1,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] out,
    output logic [4:0]       cond_out,
    output logic             out_valid
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic {ST_IDLE, ST_DIV} state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;
    logic [4:0]       r_cond;
    logic [4:0]       r_flags;
    logic             r_mod;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;

    logic [4:0]       w_flags;
    logic             w_big;
    logic             w_is_div;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_dvd_nx;

    assign w_flags  = {$signed(reg0) > $signed(reg1), $signed(reg0) < $signed(reg1),
                       reg0 > reg1, reg0 < reg1, reg0 == reg1};
    assign w_big    = reg1 >= W_VAL;
    assign w_is_div = alu_op[3:1] == 3'b110;
    assign w_rot    = reg1 % W_VAL;

    always_comb begin
        w_res = '0;
        case (alu_op)
            4'h0: w_res = reg0 | reg1;
            4'h1: w_res = reg0 ^ reg1;
            4'h2: w_res = reg0 & reg1;
            4'h3: w_res = w_big ? '0 : reg0 << reg1[SHW-1:0];
            4'h4: w_res = w_big ? '0 : reg0 >> reg1[SHW-1:0];
            4'h5: w_res = w_big ? {WIDTH{reg0[WIDTH-1]}} : WIDTH'($signed(reg0) >>> reg1[SHW-1:0]);
            4'h6: w_res = reg0 + reg1;
            4'h7: w_res = reg0 - reg1;
            4'h8: w_res = reg0 * reg1;
            4'h9: w_res = ~reg0;
            4'hA: w_res = '0 - reg0;
            4'hB: w_res = {{(WIDTH-1){1'b0}}, ~|reg0};
            4'hC: w_res = '1;
            4'hD: w_res = reg0;
            4'hE: w_res = (reg0 << w_rot) | (reg0 >> (W_VAL - w_rot));
            4'hF: w_res = (reg0 >> w_rot) | (reg0 << (W_VAL - w_rot));
        endcase
    end

    // Restoring step: quotient bits shift into the dividend register as its bits are consumed.
    assign w_trial  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = w_trial >= {1'b0, r_dvs};
    assign w_sub    = w_trial[WIDTH-1:0] - r_dvs;
    assign w_rem_nx = w_ge ? w_sub : w_trial[WIDTH-1:0];
    assign w_dvd_nx = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_cond  <= '0;
            r_flags <= '0;
            r_mod   <= 1'b0;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_div && reg1 != '0) begin
                            r_dvd   <= reg0;
                            r_dvs   <= reg1;
                            r_rem   <= '0;
                            r_cnt   <= CW'(WIDTH);
                            r_flags <= w_flags;
                            r_mod   <= alu_op[0];
                            r_ready <= 1'b0;
                            r_state <= ST_DIV;
                        end else begin
                            r_out   <= w_res;
                            r_cond  <= w_flags;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    r_dvd <= w_dvd_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_out   <= r_mod ? w_rem_nx : w_dvd_nx;
                        r_cond  <= r_flags;
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign out       = r_out;
    assign cond_out  = r_cond;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: randomized and directed checks of alu_seq_unit at WIDTH=16 and WIDTH=32.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v16 = 1'b0;
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [15:0] o16;
    logic [4:0]  c16;
    logic        ov16;
    logic        rdy16;
    logic        v32 = 1'b0;
    logic [3:0]  op32 = '0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [31:0] o32;
    logic [4:0]  c32;
    logic        ov32;
    logic        rdy32;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .reg0(a16), .reg1(b16),
        .alu_op(op16), .out(o16), .cond_out(c16), .out_valid(ov16)
    );

    alu_seq_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .reg0(a32), .reg1(b32),
        .alu_op(op32), .out(o32), .cond_out(c32), .out_valid(ov32)
    );

    function automatic logic [63:0] model(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        longint sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        int r = int'(b % 64'(w));
        case (op)
            4'h0: return a | b;
            4'h1: return a ^ b;
            4'h2: return a & b;
            4'h3: return (b >= 64'(w)) ? 64'd0 : (a << b) & mask;
            4'h4: return (b >= 64'(w)) ? 64'd0 : a >> b;
            4'h5: return (b >= 64'(w)) ? ((sa < 0) ? mask : 64'd0) : 64'(sa >>> b) & mask;
            4'h6: return (a + b) & mask;
            4'h7: return (a - b) & mask;
            4'h8: return (a * b) & mask;
            4'h9: return ~a & mask;
            4'hA: return (64'd0 - a) & mask;
            4'hB: return (a == 64'd0) ? 64'd1 : 64'd0;
            4'hC: return (b == 64'd0) ? mask : a / b;
            4'hD: return (b == 64'd0) ? a : a % b;
            4'hE: return ((a << r) | (a >> (w - r))) & mask;
            default: return ((a >> r) | (a << (w - r))) & mask;
        endcase
    endfunction

    function automatic logic [4:0] flags(input int w, input logic [63:0] a, input logic [63:0] b);
        longint sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        longint sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        return {sa > sb, sa < sb, a > b, a < b, a == b};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [4:0] cnd, output int edges, output int rdy_low);
        @(negedge clk);
        op16 = op; a16 = a; b16 = b; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        edges = 0;
        rdy_low = 0;
        while (!ov16 && edges < 100) begin
            if (!rdy16) rdy_low++;
            @(posedge clk); #1;
            edges++;
        end
        res = o16;
        cnd = c16;
    endtask

    task automatic run_op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int edges, output int rdy_low);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        edges = 0;
        rdy_low = 0;
        while (!ov32 && edges < 200) begin
            if (!rdy32) rdy_low++;
            @(posedge clk); #1;
            edges++;
        end
        res = o32;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o16, c16, ov16, rdy16} !== {16'h0, 5'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16 got out=%h cond=%b valid=%b ready=%b exp 0000/00000/0/1", o16, c16, ov16, rdy16);
        end
        checks++;
        if ({o32, c32, ov32, rdy32} !== {32'h0, 5'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset32 got out=%h cond=%b valid=%b ready=%b exp 0/00000/0/1", o32, c32, ov32, rdy32);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [56:0] tbl [12];
        logic [15:0] res;
        logic [4:0]  cnd;
        int edges, rdy_low, exp_edges;
        tbl = '{
            {4'h6, 16'h7FFF, 16'h0001, 16'h8000, 5'b10100},
            {4'h7, 16'h0000, 16'h0001, 16'hFFFF, 5'b01010},
            {4'h5, 16'h8001, 16'd4,    16'hF800, 5'b01100},
            {4'h4, 16'h8001, 16'd4,    16'h0800, 5'b01100},
            {4'h3, 16'h8001, 16'd16,   16'h0000, 5'b01100},
            {4'h5, 16'h8001, 16'd20,   16'hFFFF, 5'b01100},
            {4'hF, 16'h8001, 16'd1,    16'hC000, 5'b01100},
            {4'hE, 16'h8001, 16'd17,   16'h0003, 5'b01100},
            {4'hC, 16'h1234, 16'h0000, 16'hFFFF, 5'b10100},
            {4'hD, 16'h1234, 16'h0000, 16'h1234, 5'b10100},
            {4'hC, 16'd100,  16'd7,    16'h000E, 5'b10100},
            {4'hD, 16'd100,  16'd7,    16'h0002, 5'b10100}
        };
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i][56:53], tbl[i][52:37], tbl[i][36:21], res, cnd, edges, rdy_low);
            exp_edges = (tbl[i][56:54] == 3'b110 && tbl[i][36:21] != 16'h0) ? 16 : 0;
            checks++;
            if (res !== tbl[i][20:5]) begin
                errors++;
                $display("FAIL directed[%0d] out got=%h exp=%h", i, res, tbl[i][20:5]);
            end
            checks++;
            if (cnd !== tbl[i][4:0]) begin
                errors++;
                $display("FAIL directed[%0d] cond got=%b exp=%b", i, cnd, tbl[i][4:0]);
            end
            checks++;
            if (edges !== exp_edges || rdy_low !== exp_edges || rdy16 !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] latency got=%0d ready_low=%0d ready=%b exp=%0d", i, edges, rdy_low, rdy16, exp_edges);
            end
            @(posedge clk); #1;
            checks++;
            if (ov16 !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d] pulse got valid=%b exp=0", i, ov16);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] res, a, b;
        logic [4:0]  cnd;
        logic [3:0]  op;
        int edges, rdy_low, exp_edges;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'h0;
                1: b = 16'($urandom_range(0, 20));
                default: b = 16'($urandom);
            endcase
            run_op(op, a, b, res, cnd, edges, rdy_low);
            exp_edges = (op[3:1] == 3'b110 && b != 16'h0) ? 16 : 0;
            checks++;
            if (res !== 16'(model(16, op, 64'(a), 64'(b))) || cnd !== flags(16, 64'(a), 64'(b))) begin
                errors++;
                $display("FAIL random op=%h a=%h b=%h got out=%h cond=%b exp out=%h cond=%b", op, a, b, res, cnd,
                         16'(model(16, op, 64'(a), 64'(b))), flags(16, 64'(a), 64'(b)));
            end
            checks++;
            if (edges !== exp_edges || rdy_low !== exp_edges) begin
                errors++;
                $display("FAIL random latency op=%h got=%0d ready_low=%0d exp=%0d", op, edges, rdy_low, exp_edges);
            end
        end
    endtask

    task automatic test_streaming();
        logic [15:0] a, b;
        logic [3:0]  op;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = (op[3:1] == 3'b110) ? 16'h0 : 16'($urandom_range(0, 40));
            op16 = op; a16 = a; b16 = b; v16 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({ov16, o16, c16} !== {1'b1, 16'(model(16, op, 64'(a), 64'(b))), flags(16, 64'(a), 64'(b))}) begin
                errors++;
                $display("FAIL stream[%0d] op=%h got valid=%b out=%h cond=%b exp 1/%h/%b", i, op, ov16, o16, c16,
                         16'(model(16, op, 64'(a), 64'(b))), flags(16, 64'(a), 64'(b)));
            end
        end
        v16 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int edges = 0;
        @(negedge clk);
        op16 = 4'hC; a16 = 16'hFFFF; b16 = 16'h0010; v16 = 1'b1;
        @(posedge clk); #1;
        op16 = 4'h6; a16 = 16'd2; b16 = 16'd3;
        while (!ov16 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges !== 16 || o16 !== 16'h0FFF || rdy16 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_div got edges=%0d out=%h ready=%b exp 16/0fff/1", edges, o16, rdy16);
        end
        @(posedge clk); #1;
        v16 = 1'b0;
        checks++;
        if (ov16 !== 1'b1 || o16 !== 16'h0005) begin
            errors++;
            $display("FAIL b2b_add got valid=%b out=%h exp 1/0005", ov16, o16);
        end
        @(posedge clk); #1;
        checks++;
        if (ov16 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail got valid=%b exp 0", ov16);
        end
    endtask

    task automatic test_reset_mid_div();
        int saw = 0;
        @(negedge clk);
        op16 = 4'hC; a16 = 16'hFFFF; b16 = 16'd3; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        op16 = 4'h6; a16 = 16'd1; b16 = 16'd1; v16 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (ov16) saw++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        v16 = 1'b0;
        checks++;
        if ({o16, c16, ov16, rdy16} !== {16'h0, 5'h0, 1'b0, 1'b1} || saw != 0) begin
            errors++;
            $display("FAIL reset_mid_div got out=%h cond=%b valid=%b ready=%b pulses=%0d exp 0000/00000/0/1/0",
                     o16, c16, ov16, rdy16, saw);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (ov16 || !rdy16) saw++;
        end
        checks++;
        if (saw != 0) begin
            errors++;
            $display("FAIL reset_abort got stray_events=%0d exp 0", saw);
        end
    endtask

    task automatic test_w32();
        logic [31:0] res, a, b;
        int edges, rdy_low;
        run_op32(4'h8, 32'h0001_0000, 32'h0001_0000, res, edges, rdy_low);
        checks++;
        if (res !== 32'h0 || edges !== 0) begin
            errors++;
            $display("FAIL w32_mul got out=%h edges=%0d exp 00000000/0", res, edges);
        end
        run_op32(4'hC, 32'h1234_5678, 32'h0, res, edges, rdy_low);
        checks++;
        if (res !== 32'hFFFF_FFFF || edges !== 0) begin
            errors++;
            $display("FAIL w32_div0 got out=%h edges=%0d exp ffffffff/0", res, edges);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'h0) b = 32'd1;
            run_op32(4'hC | 4'(i & 1), a, b, res, edges, rdy_low);
            checks++;
            if (res !== 32'(model(32, 4'hC | 4'(i & 1), 64'(a), 64'(b))) || edges !== 32 || rdy_low !== 32) begin
                errors++;
                $display("FAIL w32_div[%0d] a=%h b=%h got out=%h edges=%0d ready_low=%0d exp out=%h edges=32",
                         i, a, b, res, edges, rdy_low, 32'(model(32, 4'hC | 4'(i & 1), 64'(a), 64'(b))));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_streaming();
        test_back_to_back();
        test_reset_mid_div();
        test_w32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the single-cycle ALU. It sits between register-file read and writeback and accepts one operation per handshake. It implements the full 16-entry opcode map, including iterative unsigned divide/modulo and rotates. All other ops complete in one cycle; divide/modulo take WIDTH cycles, with back-pressure through `in_ready`.

## Interface
- `WIDTH`, default 16: operand/result width; integer ≥ 4. `SHW = $clog2(WIDTH)`.
- `clk`  in  1: clock; all logic on rising edge.
- `rst_n`  in  1: synchronous reset, active-low, sampled on `clk` rising edge.
- `in_valid`  in  1: operands and opcode valid.
- `in_ready`  out  1: unit can accept. High only in IDLE.
- `reg0`  in  WIDTH: operand A.
- `reg1`  in  WIDTH: operand B / shift amount / divisor.
- `alu_op`  in  4: opcode.
- `out`  out  WIDTH: result. Holds its value until the next result.
- `cond_out`  out  5: `{sgt, slt, ugt, ult, eq}` of the accepted `reg0` vs `reg1`. Delivered with `out`.
- `out_valid`  out  1: one-cycle pulse; `out` and `cond_out` are valid.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`. Operands, op and compare flags are captured at that edge.
- Opcodes (results truncated to WIDTH):
  - 0x0 OR; 0x1 XOR; 0x2 AND.
  - 0x3 `reg0 << reg1`: result is 0 if `reg1 ≥ WIDTH`.
  - 0x4 logical right shift: result is 0 if `reg1 ≥ WIDTH`.
  - 0x5 arithmetic right shift (sign-fill): if `reg1 ≥ WIDTH`, all bits equal `reg0[WIDTH-1]`.
  - 0x6 add; 0x7 subtract; 0x8 multiply (low WIDTH bits).
  - 0x9 bitwise NOT `reg0`; 0xA two's-complement negate `reg0`.
  - 0xB logical NOT: 1 if `reg0 == 0`, else 0.
  - 0xC unsigned quotient; 0xD unsigned remainder.
  - 0xE rotate left by `reg1 mod WIDTH`; 0xF rotate right by `reg1 mod WIDTH`.
- State machine, IDLE / DIV:
  - IDLE, accept of ops 0x0–0xB, 0xE, 0xF, or 0xC/0xD with `reg1 == 0`: write `out`/`cond_out`, pulse `out_valid`, stay in IDLE.
  - IDLE, accept of 0xC/0xD with `reg1 != 0`: load dividend, divisor, partial remainder = 0, count = WIDTH; go to DIV.
  - DIV: one restoring-division step per cycle (shift one dividend bit into the remainder, trial-subtract, set quotient bit), and count decrements. On the step where count reaches 0, write the quotient (0xC) or remainder (0xD) to `out`, write the captured flags to `cond_out`, pulse `out_valid`, and return to IDLE.
- Divide by zero: quotient is all ones; remainder is `reg0`. Completes with single-cycle latency.
- `in_valid` during DIV is ignored; the upstream block holds its inputs.

## Timing
- Reset values: `out = 0`, `cond_out = 0`, `out_valid = 0`, `in_ready = 1`, state IDLE, count = 0.
- Single-cycle ops: accept at edge E0; `out_valid` high in the cycle after E0.
- Divide/modulo (`reg1 != 0`): accept at E0; steps occur at edges E1..E(WIDTH). `out_valid` is high in the cycle after E(WIDTH), so latency is WIDTH cycles. `in_ready` is low from after E0 through E(WIDTH).
- `in_ready` rises in the same cycle `out_valid` pulses for a divide. A new op may be accepted at the next edge, giving zero bubble.
- Back-to-back single-cycle ops sustain 1 op/cycle, with `out_valid` high continuously.
- Reset mid-divide: the operation is aborted with no `out_valid`, and outputs take their reset values at that edge.
- `rst_n` low overrides an accept at the same edge.
- `out_valid` never stays high for two cycles for the same operation.

## Test plan
- Reset: assert `rst_n` low for 2 cycles at DIV step 5 → no `out_valid`; `in_ready = 1`, `out = 0x0000`, `cond_out = 0` on the following cycle.
- WIDTH=16, op 0x6, `0x7FFF + 0x0001` → `out = 0x8000`, `cond_out = 5'b10100`, `out_valid` exactly 1 cycle after accept. Op 0x7, `0x0000 - 0x0001` → `0xFFFF`, `cond_out = 5'b01010`.
- Op 0xC, `100 / 7` → `out = 0x000E`, `in_ready` low for 16 cycles, `out_valid` 16 cycles after accept. Op 0xD, same operands → `0x0002`.
- Divide by zero, `0x1234` and `reg1 = 0`: op 0xC → `0xFFFF`; op 0xD → `0x1234`. Both with 1-cycle latency; `in_ready` never drops.
- Shifts/rotates with `reg0 = 0x8001`:
  - op 0x5 by 4 → `0xF800`; op 0x4 by 4 → `0x0800`.
  - op 0x3 by 16 → `0x0000`; op 0x5 by 20 → `0xFFFF`.
  - op 0xF by 1 → `0xC000`; op 0xE by 17 → `0x0003`.
- Back-to-back: divide `0xFFFF / 0x0010` with op 0x6 `2 + 3` held valid behind it → `out = 0x0FFF` pulse, add accepted that same cycle, then `out = 0x0005` next cycle.
- WIDTH=32 build: op 0x8, `0x00010000 * 0x00010000` → `0x00000000`; divide latency 32 cycles.
